// File: rtl/regfile_dump_reader.sv
// Debug read-out engine: walks the register file through one read port and
// streams each register value with its index over a valid/ready interface.
module regfile_dump_reader #(
  parameter int NREG = 8,
  parameter int DW   = 16,
  localparam int IW  = $clog2(NREG)
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Start,
  input  logic          Single,
  input  logic [IW-1:0] Sel,
  output logic [IW-1:0] SR_SEL,
  input  logic [DW-1:0] SR_DATA,
  output logic [DW-1:0] Out_Data,
  output logic [IW-1:0] Out_Idx,
  output logic          Out_Last,
  output logic          Out_Valid,
  input  logic          Out_Ready,
  output logic          Busy,
  output logic          Done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [IW-1:0] lastIdx_q, lastIdx_d;
  logic [DW-1:0] outData_q, outData_d;
  logic [IW-1:0] outIdx_q, outIdx_d;
  logic          outLast_q, outLast_d;
  logic          outValid_q, outValid_d;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      lastIdx_q  <= '0;
      outData_q  <= '0;
      outIdx_q   <= '0;
      outLast_q  <= 1'b0;
      outValid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      lastIdx_q  <= lastIdx_d;
      outData_q  <= outData_d;
      outIdx_q   <= outIdx_d;
      outLast_q  <= outLast_d;
      outValid_q <= outValid_d;
    end
  end

  // SR_DATA is sampled at the posedge ending LOAD, so a write landing on that
  // same edge is not seen and the pre-write value goes out.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    lastIdx_d  = lastIdx_q;
    outData_d  = outData_q;
    outIdx_d   = outIdx_q;
    outLast_d  = outLast_q;
    outValid_d = outValid_q;
    unique case (state_q)
      IDLE: begin
        if (Start) begin
          idx_d     = Single ? Sel : '0;
          lastIdx_d = Single ? Sel : IW'(NREG - 1);
          state_d   = LOAD;
        end
      end
      LOAD: begin
        outData_d  = SR_DATA;
        outIdx_d   = idx_q;
        outLast_d  = (idx_q == lastIdx_q);
        outValid_d = 1'b1;
        state_d    = SEND;
      end
      SEND: begin
        if (Out_Ready) begin
          outValid_d = 1'b0;
          if (outLast_q) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + IW'(1);
            state_d = LOAD;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign SR_SEL    = idx_q;
  assign Out_Data  = outData_q;
  assign Out_Idx   = outIdx_q;
  assign Out_Last  = outLast_q;
  assign Out_Valid = outValid_q;
  assign Busy      = (state_q != IDLE);
  assign Done      = (state_q == DONE);

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Bench for regfile_dump_reader: a small register-file model with a write port,
// a vector table of dump requests, and hand-written collision/reset sequences.
module tb_regfile_dump_reader;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Start;
  logic        Single;
  logic [2:0]  Sel;
  logic [2:0]  SR_SEL;
  logic [15:0] SR_DATA;
  logic [15:0] Out_Data;
  logic [2:0]  Out_Idx;
  logic        Out_Last;
  logic        Out_Valid;
  logic        Out_Ready;
  logic        Busy;
  logic        Done;

  logic        initRegs;
  logic        wrEn;
  logic [2:0]  wrAddr;
  logic [15:0] wrData;
  logic [15:0] regs [8];
  logic [15:0] expRegs [8];

  int checks = 0;
  int failures = 0;

  int gotCount;
  int doneCycle;
  int gotIdx [16];
  int gotData [16];
  int gotLast [16];

  regfile_dump_reader #(.NREG(8), .DW(16)) dut (
    .Clk(Clk),
    .Reset(Reset),
    .Start(Start),
    .Single(Single),
    .Sel(Sel),
    .SR_SEL(SR_SEL),
    .SR_DATA(SR_DATA),
    .Out_Data(Out_Data),
    .Out_Idx(Out_Idx),
    .Out_Last(Out_Last),
    .Out_Valid(Out_Valid),
    .Out_Ready(Out_Ready),
    .Busy(Busy),
    .Done(Done)
  );

  always #5 Clk = ~Clk;

  // Register file model: combinational read, posedge write.
  always @(posedge Clk) begin
    if (initRegs) begin
      for (int i = 0; i < 8; i++) regs[i] <= 16'h1000 + 16'(i);
    end else if (wrEn) begin
      regs[wrAddr] <= wrData;
    end
  end
  assign SR_DATA = regs[SR_SEL];

  typedef struct {
    logic        single;
    logic [2:0]  sel;
    logic        doWr;
    logic [2:0]  wrA;
    logic [15:0] wrD;
    int          stallIdx;
    int          stallLen;
    int          expFirst;
    int          expWords;
    int          expDone;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic checkResetOutputs(input string tag);
    check({tag, "_busy"}, 32'(Busy), 32'd0);
    check({tag, "_valid"}, 32'(Out_Valid), 32'd0);
    check({tag, "_done"}, 32'(Done), 32'd0);
    check({tag, "_data"}, 32'(Out_Data), 32'd0);
    check({tag, "_idx"}, 32'(Out_Idx), 32'd0);
    check({tag, "_last"}, 32'(Out_Last), 32'd0);
    check({tag, "_srsel"}, 32'(SR_SEL), 32'd0);
  endtask

  task automatic writeReg(input logic [2:0] a, input logic [15:0] d);
    wrEn = 1'b1;
    wrAddr = a;
    wrData = d;
    tick();
    wrEn = 1'b0;
    expRegs[a] = d;
  endtask

  // Issues one request and records every accepted word. Cycle 0 is the Start
  // cycle; stall/write/reset hooks are keyed on word index or cycle number.
  task automatic applyStimulus(input logic single, input logic [2:0] sel,
                               input int stallIdx, input int stallLen, input int lastIdx,
                               input int wrCycle, input logic [2:0] wrA, input logic [15:0] wrD,
                               input int resetAfter);
    int cnt = 0;
    int stalled = 0;
    bit pendReset = 0;
    bit inReset = 0;
    bit aborted = 0;
    gotCount = 0;
    doneCycle = -1;
    Single = single;
    Sel = sel;
    Start = 1'b1;
    Out_Ready = 1'b1;
    while (doneCycle < 0 && !aborted && cnt < 80) begin
      tick();
      cnt++;
      Start = 1'b0;
      wrEn = 1'b0;
      if (inReset) begin
        Reset = 1'b0;
        checkResetOutputs("midReset");
        aborted = 1;
        continue;
      end
      if (pendReset) begin
        Reset = 1'b1;
        pendReset = 0;
        inReset = 1;
        continue;
      end
      if (cnt == wrCycle) begin
        wrEn = 1'b1;
        wrAddr = wrA;
        wrData = wrD;
      end
      if (cnt == 1) check("busyAtLoad", 32'(Busy), 32'd1);
      if (Done) doneCycle = cnt;
      if (Out_Valid && int'(Out_Idx) == stallIdx && stalled < stallLen) begin
        Out_Ready = 1'b0;
        stalled++;
        check($sformatf("stall%0d_data", stalled), 32'(Out_Data), 32'(expRegs[stallIdx]));
        check($sformatf("stall%0d_idx", stalled), 32'(Out_Idx), 32'(stallIdx));
        check($sformatf("stall%0d_last", stalled), 32'(Out_Last), 32'(stallIdx == lastIdx));
      end else begin
        Out_Ready = 1'b1;
        if (Out_Valid && gotCount < 16) begin
          gotIdx[gotCount]  = int'(Out_Idx);
          gotData[gotCount] = int'(Out_Data);
          gotLast[gotCount] = int'(Out_Last);
          gotCount++;
          if (int'(Out_Idx) == resetAfter) pendReset = 1;
        end
      end
    end
    wrEn = 1'b0;
    Out_Ready = 1'b1;
    if (doneCycle >= 0) begin
      tick();
      check("donePulseEnds", 32'(Done), 32'd0);
      check("idleAfterDone", 32'(Busy), 32'd0);
    end
  endtask

  task automatic checkOutput(input string tag, input int first, input int words,
                             input int lastK, input int expDone);
    check({tag, "_count"}, 32'(gotCount), 32'(words));
    check({tag, "_doneCycle"}, 32'(doneCycle), 32'(expDone));
    for (int k = 0; k < words && k < gotCount; k++) begin
      check($sformatf("%s_w%0d_idx", tag, k), 32'(gotIdx[k]), 32'(first + k));
      check($sformatf("%s_w%0d_data", tag, k), 32'(gotData[k]), 32'(expRegs[first + k]));
      check($sformatf("%s_w%0d_last", tag, k), 32'(gotLast[k]), 32'(k == lastK));
    end
  endtask

  initial begin
    vecs[0] = '{single: 1'b0, sel: 3'd0, doWr: 1'b0, wrA: 3'd0, wrD: 16'h0,
                stallIdx: -1, stallLen: 0, expFirst: 0, expWords: 8, expDone: 17};
    vecs[1] = '{single: 1'b1, sel: 3'd5, doWr: 1'b1, wrA: 3'd5, wrD: 16'hBEEF,
                stallIdx: -1, stallLen: 0, expFirst: 5, expWords: 1, expDone: 3};
    vecs[2] = '{single: 1'b1, sel: 3'd0, doWr: 1'b0, wrA: 3'd0, wrD: 16'h0,
                stallIdx: -1, stallLen: 0, expFirst: 0, expWords: 1, expDone: 3};
    vecs[3] = '{single: 1'b1, sel: 3'd7, doWr: 1'b0, wrA: 3'd0, wrD: 16'h0,
                stallIdx: -1, stallLen: 0, expFirst: 7, expWords: 1, expDone: 3};
    vecs[4] = '{single: 1'b0, sel: 3'd0, doWr: 1'b0, wrA: 3'd0, wrD: 16'h0,
                stallIdx: 2, stallLen: 5, expFirst: 0, expWords: 8, expDone: 22};

    Reset = 1'b1;
    initRegs = 1'b1;
    Start = 1'b0;
    Single = 1'b0;
    Sel = 3'd0;
    Out_Ready = 1'b0;
    wrEn = 1'b0;
    wrAddr = 3'd0;
    wrData = 16'h0;
    for (int i = 0; i < 8; i++) expRegs[i] = 16'h1000 + 16'(i);
    repeat (3) tick();
    Reset = 1'b0;
    initRegs = 1'b0;

    for (int c = 0; c < 20; c++) begin
      check($sformatf("idle%0d_busy", c), 32'(Busy), 32'd0);
      check($sformatf("idle%0d_valid", c), 32'(Out_Valid), 32'd0);
      check($sformatf("idle%0d_done", c), 32'(Done), 32'd0);
      tick();
    end
    checkResetOutputs("reset");

    for (int v = 0; v < 5; v++) begin
      int lastK;
      if (vecs[v].doWr) writeReg(vecs[v].wrA, vecs[v].wrD);
      lastK = vecs[v].expWords - 1;
      applyStimulus(vecs[v].single, vecs[v].sel, vecs[v].stallIdx, vecs[v].stallLen,
                    vecs[v].expFirst + lastK, -1, 3'd0, 16'h0, -1);
      checkOutput($sformatf("vec%0d", v), vecs[v].expFirst, vecs[v].expWords, lastK,
                  vecs[v].expDone);
      tick();
    end

    // Write to R3 on the edge ending its LOAD: old value must be sent.
    applyStimulus(1'b0, 3'd0, -1, 0, 7, 7, 3'd3, 16'hAAAA, -1);
    checkOutput("collision", 0, 8, 7, 17);
    expRegs[3] = 16'hAAAA;
    tick();
    applyStimulus(1'b0, 3'd0, -1, 0, 7, -1, 3'd0, 16'h0, -1);
    checkOutput("afterCollision", 0, 8, 7, 17);
    tick();

    // Reset one cycle after word 4 is accepted; no Done, restart from R0.
    applyStimulus(1'b0, 3'd0, -1, 0, 7, -1, 3'd0, 16'h0, 4);
    checkOutput("midReset", 0, 5, -1, -1);
    tick();
    check("postReset_done", 32'(Done), 32'd0);
    applyStimulus(1'b0, 3'd0, -1, 0, 7, -1, 3'd0, 16'h0, -1);
    checkOutput("restart", 0, 8, 7, 17);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_dump_reader.md
# regfile_dump_reader

Debug read-out engine that sits beside the LC-3 register file and streams register contents out over a valid/ready interface. It owns one of the register file's source-select read ports while active, walks registers R0..R(NREG-1) in ascending order (or reads one selected register), and hands each value with its index to a downstream consumer such as the hex-display or UART debug path. It never writes the register file.

## Interface
- NREG, 8, number of registers scanned; power of two, ≥2; IW = $clog2(NREG)
- DW, 16, register data width
- Clk  in  1  clock, all state updates on posedge
- Reset  in  1  synchronous, active-high; returns block to IDLE
- Start  in  1  request; sampled only in IDLE
- Single  in  1  sampled with Start; 1 = read only register Sel, 0 = full dump
- Sel  in  IW  register index for single mode, sampled with Start
- SR_SEL  out  IW  select driven to the register file read port (combinational read)
- SR_DATA  in  DW  read data returned by the register file for SR_SEL
- Out_Data  out  DW  captured register value
- Out_Idx  out  IW  index of the register in Out_Data
- Out_Last  out  1  high with Out_Valid on the final word of the request
- Out_Valid  out  1  output word available
- Out_Ready  in  1  consumer accepts word when Out_Valid & Out_Ready
- Busy  out  1  high in every state except IDLE
- Done  out  1  one-cycle pulse after the last word is accepted

## Operation
- States: IDLE, LOAD, SEND, DONE; all outputs registered.
- IDLE: Busy=0, Out_Valid=0. On Start=1: idx ← Single ? Sel : 0; last_idx ← Single ? Sel : NREG-1; go to LOAD.
- LOAD: SR_SEL = idx (registered, so valid for the whole cycle); at the posedge Out_Data ← SR_DATA, Out_Idx ← idx, Out_Last ← (idx == last_idx), Out_Valid ← 1; go to SEND.
- SEND: Out_Data/Out_Idx/Out_Last held stable while Out_Valid=1 and Out_Ready=0. On handshake: Out_Valid ← 0; if Out_Last go to DONE, else idx ← idx+1, go to LOAD.
- DONE: Done=1 for exactly this cycle, Busy=1; next state IDLE.
- Snapshot semantics: each value is the register content as sampled during its LOAD cycle. A register-file write landing on the same posedge that ends LOAD is not captured (pre-write value is sent); writes to already-sent registers are not re-sent.
- Start, Single, Sel ignored outside IDLE; Start held high through DONE starts a new request only after IDLE is re-entered.
- idx never wraps: full dump ends at NREG-1; single mode ends after one word.
- SR_SEL in IDLE/DONE holds its last value (reset value 0); the datapath must not rely on it outside Busy.

## Timing
- Reset values: state IDLE, SR_SEL=0, Out_Data=0, Out_Idx=0, Out_Last=0, Out_Valid=0, Busy=0, Done=0, idx=0.
- Reset mid-request: next cycle is IDLE with all outputs at reset values; an un-accepted word is dropped; no Done.
- Start at cycle t (IDLE) → LOAD at t+1 (Busy=1) → Out_Valid=1 at t+2.
- With Out_Ready held 1: one word per 2 cycles; full dump of NREG=8 occupies cycles t+1..t+16, Done at t+17, IDLE at t+18. Single read: Done at t+3.
- Out_Ready may be asserted before Out_Valid; acceptance only counts in SEND with Out_Valid=1.
- Back-pressure of any length stalls in SEND with no data change.

## Test plan
- Reset then idle: regs R0..R7 = 0x1000+i; no Start for 20 cycles → Busy=0, Out_Valid=0, Done=0, all outputs 0.
- Full dump, Out_Ready=1: Start with Single=0 → 8 words Out_Idx 0..7, Out_Data 0x1000..0x1007, Out_Last only on idx 7, Done at Start+17.
- Single read: Single=1, Sel=5, R5=0xBEEF → one word Out_Idx=5, Out_Data=0xBEEF, Out_Last=1, Done at Start+3.
- Back-pressure: Out_Ready low for 5 cycles on word idx 2 → Out_Data/Out_Idx/Out_Last stable all 5 cycles, then sequence continues 3..7 unchanged.
- Write collision: LD writes 0xAAAA to R3 on the posedge ending LOAD for idx 3 (old 0x1003) → word 3 carries 0x1003; restarted dump then carries 0xAAAA.
- Reset mid-dump after word 4 accepted: assert Reset one cycle → outputs at reset values, no Done; new Start dumps from idx 0.
